// File: rtl/lcd_byte_writer.sv
// ============================================================================
// Module   : lcd_byte_writer
// Brief    : Writes one HD44780 byte through a PCF8574 expander (4-bit mode)
//            as four single-byte I2C writes plus a settle delay.
//            Optional macro LCD_WRITER_BACKLIGHT_EN adds the backlight input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_byte_writer #(
    parameter logic [6:0] I2C_ADDR   = 7'h27,
    parameter int         POST_DELAY = 50
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       cmd_data,
`ifdef LCD_WRITER_BACKLIGHT_EN
    input  logic       backlight,
`endif
    output logic       done_write,
    output logic       busy,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_byte,
    input  logic       i2c_done,
    input  logic       i2c_ack_err,
    output logic       nack_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_DELAY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] c_delay_last = 16'(POST_DELAY - 1);

    state_t      r_state;
    logic [1:0]  r_index;
    logic [15:0] r_count;
    logic [7:0]  r_data;
    logic        r_rs;
    logic        r_bl;
    logic        w_bl;

`ifdef LCD_WRITER_BACKLIGHT_EN
    assign w_bl = backlight;
`else
    assign w_bl = 1'b1;
`endif

    assign i2c_addr = I2C_ADDR;

    // Even index raises EN, odd index drops it; index[1] selects the low nibble.
    function automatic logic [7:0] f_exp_byte(input logic [1:0] idx, input logic [7:0] d,
                                              input logic bl, input logic rs);
        logic [3:0] nib;
        nib = idx[1] ? d[3:0] : d[7:4];
        return {nib, bl, ~idx[0], 1'b0, rs};
    endfunction

    // Outputs are registered on the edge that enters the state they belong to.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_index    <= 2'd0;
            r_count    <= 16'd0;
            r_data     <= 8'h00;
            r_rs       <= 1'b0;
            r_bl       <= 1'b0;
            done_write <= 1'b0;
            busy       <= 1'b0;
            i2c_ena    <= 1'b0;
            i2c_byte   <= 8'h00;
            nack_err   <= 1'b0;
        end else begin
            i2c_ena    <= 1'b0;
            done_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ena_write) begin
                        r_data   <= data;
                        r_rs     <= cmd_data;
                        r_bl     <= w_bl;
                        r_index  <= 2'd0;
                        nack_err <= 1'b0;
                        busy     <= 1'b1;
                        i2c_ena  <= 1'b1;
                        i2c_byte <= f_exp_byte(2'd0, data, w_bl, cmd_data);
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        nack_err <= nack_err | i2c_ack_err;
                        if (r_index == 2'd3) begin
                            r_count <= 16'd0;
                            r_state <= S_DELAY;
                        end else begin
                            r_index  <= r_index + 2'd1;
                            i2c_ena  <= 1'b1;
                            i2c_byte <= f_exp_byte(r_index + 2'd1, r_data, r_bl, r_rs);
                            r_state  <= S_SEND;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_count == c_delay_last) begin
                        done_write <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_byte_writer.sv
// ============================================================================
// Module   : tb_lcd_byte_writer
// Brief    : Scoreboard bench for lcd_byte_writer with a behavioural I2C master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_byte_writer;

    localparam int P = 4;

    logic       clk_1MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_write = 1'b0;
    logic [7:0] data = 8'h00;
    logic       cmd_data = 1'b0;
`ifdef LCD_WRITER_BACKLIGHT_EN
    logic       backlight = 1'b1;
`endif
    logic       i2c_done = 1'b0;
    logic       i2c_ack_err = 1'b0;
    logic       done_write, busy, i2c_ena, nack_err;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_byte;

    lcd_byte_writer #(.I2C_ADDR(7'h27), .POST_DELAY(P)) dut (
        .clk_1MHz    (clk_1MHz),
        .rst_n       (rst_n),
        .ena_write   (ena_write),
        .data        (data),
        .cmd_data    (cmd_data),
`ifdef LCD_WRITER_BACKLIGHT_EN
        .backlight   (backlight),
`endif
        .done_write  (done_write),
        .busy        (busy),
        .i2c_ena     (i2c_ena),
        .i2c_addr    (i2c_addr),
        .i2c_byte    (i2c_byte),
        .i2c_done    (i2c_done),
        .i2c_ack_err (i2c_ack_err),
        .nack_err    (nack_err)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int cyc = 0;
    always @(posedge clk_1MHz) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int q_byte[$];
    int q_bcyc[$];
    int q_dcyc[$];
    int q_nack[$];
    int cfg_wait = 0;
    int cfg_nack_idx = -1;
    int m_cnt = 0;
    int m_idx = 0;
    logic m_nack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // I2C master: done arrives cfg_wait cycles after the first WAIT cycle.
    always @(negedge clk_1MHz) begin
        i2c_done    = 1'b0;
        i2c_ack_err = 1'b0;
        if (!rst_n) begin
            m_cnt = 0;
            m_idx = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i2c_done    = 1'b1;
                    i2c_ack_err = m_nack;
                end
            end
            if (i2c_ena) begin
                m_cnt  = 1 + cfg_wait;
                m_nack = (m_idx == cfg_nack_idx);
                m_idx  = (m_idx + 1) % 4;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or completion.
    always @(negedge clk_1MHz) begin
        if (rst_n) begin
            if (i2c_ena) begin
                if (q_byte.size() == 0) chk("unexpected_i2c_ena", 1, 0);
                else begin
                    chk("i2c_byte", i2c_byte, q_byte.pop_front());
                    chk("i2c_ena_cycle", cyc, q_bcyc.pop_front());
                    chk("i2c_addr", i2c_addr, 7'h27);
                end
            end
            if (done_write) begin
                if (q_dcyc.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    chk("done_cycle", cyc, q_dcyc.pop_front());
                    chk("nack_err_at_done", nack_err, q_nack.pop_front());
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input logic rs, input logic bl,
                              input int w, input int nidx, input bit reissue, input bit abort);
        int acc, t, nib, ev;
        @(negedge clk_1MHz);
        cfg_wait     = w;
        cfg_nack_idx = nidx;
        ena_write    = 1'b1;
        data         = d;
        cmd_data     = rs;
`ifdef LCD_WRITER_BACKLIGHT_EN
        backlight    = bl;
`endif
        acc = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            nib = (k < 2) ? int'(d) / 16 : int'(d) % 16;
            ev  = nib * 16 + (bl ? 8 : 0) + ((k % 2 == 0) ? 4 : 0) + (rs ? 1 : 0);
            q_byte.push_back(ev);
            q_bcyc.push_back(acc + k * (2 + w));
        end
        if (!abort) begin
            q_dcyc.push_back(acc + 8 + P + 4 * w);
            q_nack.push_back((nidx >= 0 && nidx < 4) ? 1 : 0);
        end
        @(negedge clk_1MHz);
        ena_write = 1'b0;
        data      = 8'($urandom);
        cmd_data  = ~rs;
        chk("busy_cycle1", busy, 1);
        chk("nack_clear_on_accept", nack_err, 0);
        if (reissue) begin
            @(negedge clk_1MHz);
            ena_write = 1'b1;
            @(negedge clk_1MHz);
            ena_write = 1'b0;
        end
        if (abort) begin
            while (cyc < acc + 9 + 4 * w) @(negedge clk_1MHz);
            rst_n = 1'b0;
            @(negedge clk_1MHz);
            chk("abort_busy", busy, 0);
            chk("abort_done", done_write, 0);
            chk("abort_i2c_byte", i2c_byte, 8'h00);
            chk("abort_i2c_ena", i2c_ena, 0);
            chk("abort_nack", nack_err, 0);
            rst_n = 1'b1;
            repeat (P + 12) @(negedge clk_1MHz);
        end else begin
            t = 0;
            while (!done_write && t < 400) begin
                @(negedge clk_1MHz);
                t++;
            end
            chk("done_timeout", done_write, 1);
            @(negedge clk_1MHz);
            chk("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rrs, rbl;
        int         rw, rn;
        repeat (3) @(negedge clk_1MHz);
        chk("rst_done", done_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_i2c_ena", i2c_ena, 0);
        chk("rst_nack", nack_err, 0);
        chk("rst_i2c_byte", i2c_byte, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_1MHz);
        chk("idle_busy", busy, 0);
        chk("idle_i2c_byte", i2c_byte, 8'h00);

        write_byte(8'h41, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0);
        write_byte(8'h01, 1'b0, 1'b1, 5, -1, 1'b0, 1'b0);
        write_byte(8'h5A, 1'b1, 1'b1, 0, -1, 1'b1, 1'b0);
        write_byte(8'hC3, 1'b0, 1'b1, 2,  1, 1'b0, 1'b0);
        write_byte(8'h7E, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0);
        write_byte(8'h99, 1'b0, 1'b1, 1, -1, 1'b0, 1'b1);
        write_byte(8'h41, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0);
`ifdef LCD_WRITER_BACKLIGHT_EN
        write_byte(8'h41, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 12; i++) begin
            rd  = 8'($urandom);
            rrs = 1'($urandom);
`ifdef LCD_WRITER_BACKLIGHT_EN
            rbl = 1'($urandom);
`else
            rbl = 1'b1;
`endif
            rw  = int'($urandom_range(0, 3));
            rn  = int'($urandom_range(0, 4));
            write_byte(rd, rrs, rbl, rw, (rn == 4) ? -1 : rn, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(negedge clk_1MHz);
        chk("bytes_left", q_byte.size(), 0);
        chk("done_left", q_dcyc.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
